// File: rtl/fsub_serial.sv
// -----------------------------------------------------------------------------
// fsub_serial
//
// Bit-serial WIDTH-bit subtractor. A single full-subtractor cell and a borrow
// flop process the operands LSB-first, one bit per clock. The difference and
// final borrow are presented in parallel and held until the next accepted
// start.
//
// Handshake: start is a request that is accepted on any rising edge where the
// unit is in IDLE or DONE. There is no ready output. A request seen while
// busy is dropped, not queued. done is a one-cycle pulse that marks diff/bout
// (and ovf) valid. Those values then hold until the next accepted start.
//
// Optional feature macro: FSUB_SERIAL_OVF_EN
//   When defined, the ovf port exists and reports signed overflow. The
//   operand sign bits are captured at load for this purpose.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   operation request
//   a      in   minuend   [WIDTH-1:0], sampled on accepted start
//   b      in   subtrahend[WIDTH-1:0], sampled on accepted start
//   bin    in   borrow-in, sampled on accepted start
//   busy   out  high while bits are being processed (RUN)
//   done   out  one-cycle result-valid pulse (DONE)
//   diff   out  a - b - bin mod 2^WIDTH
//   bout   out  final borrow-out (1 iff a < b + bin, unsigned)
//   ovf    out  signed overflow (only with FSUB_SERIAL_OVF_EN)
// -----------------------------------------------------------------------------
module fsub_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef FSUB_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_sr;
  logic             br;

  logic             accept;
  logic             last;
  logic             d;
  logic             br_nxt;

  // A request is only taken when no operation is in flight.
  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (state == RUN) && (cnt == CW'(WIDTH - 1));

  // Full-subtractor cell on the current LSBs and the stored borrow.
  assign d      = a_sr[0] ^ b_sr[0] ^ br;
  assign br_nxt = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (start) state_nxt = RUN;
        else       state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand shifters, result shifter, borrow flop, bit counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      a_sr    <= '0;
      b_sr    <= '0;
      diff_sr <= '0;
      br      <= 1'b0;
    end else if (accept) begin
      cnt     <= '0;
      a_sr    <= a;
      b_sr    <= b;
      diff_sr <= '0;
      br      <= bin;
    end else if (state == RUN) begin
      cnt     <= cnt + CW'(1);
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      // Each new bit enters at the MSB. After WIDTH shifts the first bit
      // computed has reached bit 0.
      diff_sr <= {d, diff_sr[WIDTH-1:1]};
      br      <= br_nxt;
    end
  end

`ifdef FSUB_SERIAL_OVF_EN
  logic sa;
  logic sb;
  logic ovf_q;

  // The sign bits shift out of the operand registers, so keep copies.
  // On the last RUN cycle, d is the result MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa    <= 1'b0;
      sb    <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (accept) begin
        sa <= a[WIDTH-1];
        sb <= b[WIDTH-1];
      end
      if (last) begin
        ovf_q <= (sa ^ sb) & (d ^ sa);
      end
    end
  end

  assign ovf = ovf_q;
`endif

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign diff = diff_sr;
  // The borrow flop is frozen outside RUN, so it directly holds the final borrow.
  assign bout = br;

endmodule

// File: tb/tb_fsub_serial.sv
// -----------------------------------------------------------------------------
// tb_fsub_serial
//
// Self-checking bench for fsub_serial (WIDTH=8). Results are predicted from
// plain integer arithmetic (a - b - bin). They are pushed on an expected
// queue when an operation is issued and popped by a monitor on every done
// pulse. The driver tasks also check busy/done timing cycle by cycle.
// -----------------------------------------------------------------------------
module tb_fsub_serial;

  localparam int W = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         bin   = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef FSUB_SERIAL_OVF_EN
  logic         ovf;
`endif

  always #5 clk = ~clk;

  fsub_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef FSUB_SERIAL_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int             n_checks = 0;
  int             n_errors = 0;
  int             done_cnt = 0;
  logic [W+1:0]   exp_q[$];     // {ovf, bout, diff}
  logic [W+1:0]   exp_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: signed integer arithmetic, then reduce mod 2^W.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mbin);
    int           r;
    logic [W-1:0] dd;
    logic         bo;
    logic         ov;
    r  = int'(ma) - int'(mb) - int'(mbin);
    bo = (r < 0);
    dd = W'(r + (1 << W));
    ov = (ma[W-1] != mb[W-1]) && (dd[W-1] != ma[W-1]);
    return {ov, bo, dd};
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_e = exp_q.pop_front();
        check("diff", 32'(diff), 32'(exp_e[W-1:0]));
        check("bout", 32'(bout), 32'(exp_e[W]));
`ifdef FSUB_SERIAL_OVF_EN
        check("ovf", 32'(ovf), 32'(exp_e[W+1]));
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called at a negedge while the DUT is in IDLE or DONE)
  // ---------------------------------------------------------------------------
  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbin,
                        input logic [W+1:0] e);
    start = 1'b1;
    a     = xa;
    b     = xb;
    bin   = xbin;
    exp_q.push_back(e);
    @(posedge clk);                       // accept edge k
    @(negedge clk);
    start = 1'b0;
    // Scramble the inputs: they must have no effect during RUN.
    a     = W'($urandom);
    b     = W'($urandom);
    bin   = 1'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
    for (int i = 1; i < W; i++) begin
      @(negedge clk);
      check("busy_run", {31'd0, busy} | {30'd0, done, 1'b0}, 32'd1);
    end
    @(negedge clk);                       // after edge k+W
    check("done_pulse", {30'd0, busy, done}, 32'd1);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W+1:0] e;
  } vec_t;

  vec_t dir_tab[5];

  initial begin
    int           c0;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rbin;

    dir_tab[0] = '{8'h05, 8'h03, 1'b0, {1'b0, 1'b0, 8'h02}};
    dir_tab[1] = '{8'h03, 8'h05, 1'b0, {1'b0, 1'b1, 8'hFE}};
    dir_tab[2] = '{8'h00, 8'h00, 1'b1, {1'b0, 1'b1, 8'hFF}};
    dir_tab[3] = '{8'h80, 8'h01, 1'b0, {1'b1, 1'b0, 8'h7F}};
    dir_tab[4] = '{8'h7F, 8'hFF, 1'b0, {1'b1, 1'b1, 8'h80}};

    // Reset values
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
`ifdef FSUB_SERIAL_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors, issued back to back (each start lands in DONE)
    foreach (dir_tab[i]) run_op(dir_tab[i].a, dir_tab[i].b, dir_tab[i].bin, dir_tab[i].e);

    // DONE -> IDLE without start: outputs hold
    @(negedge clk);
    check("idle_busy", {30'd0, busy, done}, 32'd0);
    check("idle_hold_diff", 32'(diff), 32'h80);
    check("idle_hold_bout", 32'(bout), 32'd1);

    // start pulsed while busy must be ignored
    c0 = done_cnt;
    start = 1'b1; a = 8'h5A; b = 8'h33; bin = 1'b0;
    exp_q.push_back(model(8'h5A, 8'h33, 1'b0));
    @(posedge clk);                       // accept k
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);                       // k+2
    @(negedge clk);
    start = 1'b1; a = 8'hFF; b = 8'h00; bin = 1'b1;
    @(posedge clk);                       // k+3, ignored
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && !done; i++) @(negedge clk);
    check("ign_done_seen", 32'(done), 32'd1);
    repeat (5) @(negedge clk);
    check("ign_one_done", 32'(done_cnt), 32'(c0 + 1));

    // Reset mid-RUN aborts with no done
    start = 1'b1; a = 8'h44; b = 8'h11; bin = 1'b0;
    @(posedge clk);                       // accept k
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);            // k+3
    @(posedge clk);                       // k+4
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_bout", 32'(bout), 32'd0);
    c0 = done_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_no_done", 32'(done_cnt), 32'(c0));
    run_op(8'h10, 8'h01, 1'b0, {1'b0, 1'b0, 8'h0F});
    @(negedge clk);

    // start held high: one result every W+1 cycles
    start = 1'b1;
    for (int n = 0; n < 8; n++) begin
      ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
      a = ra; b = rb; bin = rbin;
      exp_q.push_back(model(ra, rb, rbin));
      @(posedge clk);                     // accept
      repeat (W) @(posedge clk);
      @(negedge clk);
      check("b2b_done", 32'(done), 32'd1);
    end
    start = 1'b0;
    @(negedge clk);

    // Random sweep with random idle gaps (gap 0 exercises DONE->RUN)
    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
      if ($urandom_range(0, 15) == 0) rb = ra;
      run_op(ra, rb, rbin, model(ra, rb, rbin));
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
